// File: rtl/boot_pkg.sv
// Shared types and elaboration helpers for the boot loader: FSM states and
// decoding of the packed per-target length vector.
package boot_pkg;

    localparam int TGT_IDX_W  = 3;
    localparam int MAX_TGT    = 8;
    localparam int MAX_ADDR_W = 32;

    typedef enum logic [3:0] {
        IDLE, RD, WS, WP, WH, VF, NEXT, DONE, ERROR
    } boot_state_e;

    // Word count of target k; lens is the packed length vector zero-extended to the maximum size.
    function automatic int unsigned tgt_len(input logic [MAX_TGT*MAX_ADDR_W-1:0] lens,
                                            input int addr_w, input int k);
        int unsigned r;
        r = 0;
        for (int b = 0; b < MAX_ADDR_W; b++)
            if (b < addr_w) r[b] = lens[k*addr_w + b];
        return r;
    endfunction

    function automatic bit lens_ok(input logic [MAX_TGT*MAX_ADDR_W-1:0] lens,
                                   input int addr_w, input int n);
        longint s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            if (tgt_len(lens, addr_w, k) == 0) return 1'b0;
            s += longint'(tgt_len(lens, addr_w, k));
        end
        return s <= (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/boot_wait_ctr.sv
// Loadable down-counter timing the ROM and read-back access windows.
// Held at LAT-1 while i_load is high; o_zero flags the last cycle of a window.
module boot_wait_ctr #(
    parameter int LAT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_zero
);

    localparam int               CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load)
            r_cnt <= LOAD_VAL;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/boot_loader.sv
// Copies NUM_TGT contiguous EEPROM regions into SRAM targets after reset,
// optionally verifying each word, then drops o_n_booted.
module boot_loader
    import boot_pkg::*;
#(
    parameter int                        NUM_TGT  = 3,
    parameter int                        DATA_W   = 8,
    parameter int                        ADDR_W   = 17,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_LENS = {NUM_TGT{ADDR_W'(64)}},
    parameter int                        ROM_LAT  = 2,
    parameter bit                        VERIFY   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_reboot,
    output logic [ADDR_W-1:0]    o_rom_addr,
    output logic                 o_rom_n_oe,
    input  logic [DATA_W-1:0]    i_rom_data,
    output logic [ADDR_W-1:0]    o_tgt_addr,
    output logic [DATA_W-1:0]    o_tgt_data,
    output logic [NUM_TGT-1:0]   o_tgt_n_we,
    output logic [NUM_TGT-1:0]   o_tgt_n_oe,
    input  logic [DATA_W-1:0]    i_tgt_rdata,
    output logic                 o_n_booted,
    output logic                 o_err,
    output logic [TGT_IDX_W-1:0] o_err_tgt,
    output logic [ADDR_W-1:0]    o_err_addr
);

    localparam logic [MAX_TGT*MAX_ADDR_W-1:0] LENS_EXT = (MAX_TGT*MAX_ADDR_W)'(TGT_LENS);

    if (NUM_TGT < 1 || NUM_TGT > MAX_TGT || ADDR_W < 1 || ADDR_W > MAX_ADDR_W ||
        ROM_LAT < 1 || !lens_ok(LENS_EXT, ADDR_W, NUM_TGT)) begin : g_bad_params
        $error("boot_loader: illegal NUM_TGT/ADDR_W/ROM_LAT/TGT_LENS combination");
    end

    boot_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]    r_rom_addr, r_tgt_addr, r_err_addr;
    logic [DATA_W-1:0]    r_tgt_data;
    logic [TGT_IDX_W-1:0] r_tgt, r_err_tgt;
    logic [NUM_TGT-1:0]   r_tgt_n_we, r_tgt_n_oe, w_sel;
    logic                 r_rom_n_oe, r_n_booted, r_err;
    logic                 w_wait_zero, w_tgt_end, w_last_word, w_reboot_ok;
    logic [ADDR_W-1:0]    w_last_addr [MAX_TGT];

    // Unused table entries (k >= NUM_TGT) are never selected.
    for (genvar k = 0; k < MAX_TGT; k++) begin : g_len
        assign w_last_addr[k] = ADDR_W'(tgt_len(LENS_EXT, ADDR_W, k) - 1);
    end

    assign w_sel       = NUM_TGT'(1) << r_tgt;
    assign w_tgt_end   = (r_tgt_addr == w_last_addr[r_tgt]);
    assign w_last_word = w_tgt_end && (r_tgt == TGT_IDX_W'(NUM_TGT - 1));
    assign w_reboot_ok = i_reboot && (r_state == DONE || r_state == ERROR);

    boot_wait_ctr #(.LAT(ROM_LAT)) u_wait (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (!(r_state == RD || r_state == VF)),
        .o_zero (w_wait_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:        w_state_nxt = RD;
            RD:          if (w_wait_zero) w_state_nxt = WS;
            WS:          w_state_nxt = WP;
            WP:          w_state_nxt = WH;
            WH:          w_state_nxt = VERIFY ? VF : NEXT;
            VF:          if (w_wait_zero)
                             w_state_nxt = (i_tgt_rdata == r_tgt_data) ? NEXT : ERROR;
            NEXT:        w_state_nxt = w_last_word ? DONE : RD;
            DONE, ERROR: if (i_reboot) w_state_nxt = IDLE;
            default:     w_state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the SRAM/EEPROM pins never glitch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rom_addr <= '0;
            r_tgt_addr <= '0;
            r_tgt_data <= '0;
            r_tgt      <= '0;
            r_rom_n_oe <= 1'b1;
            r_tgt_n_we <= '1;
            r_tgt_n_oe <= '1;
            r_n_booted <= 1'b1;
            r_err      <= 1'b0;
            r_err_tgt  <= '0;
            r_err_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_n_oe <= (w_state_nxt != RD);
            r_tgt_n_we <= (w_state_nxt == WP) ? ~w_sel : '1;
            r_tgt_n_oe <= (w_state_nxt == VF) ? ~w_sel : '1;
            r_n_booted <= (w_state_nxt != DONE);
            if (r_state == RD && w_wait_zero)
                r_tgt_data <= i_rom_data;
            if (r_state == VF && w_state_nxt == ERROR) begin
                r_err      <= 1'b1;
                r_err_tgt  <= r_tgt;
                r_err_addr <= r_tgt_addr;
            end
            // On the final word the target pointers hold so they never index past NUM_TGT-1.
            if (r_state == NEXT) begin
                r_rom_addr <= r_rom_addr + 1'b1;
                if (!w_last_word) begin
                    if (w_tgt_end) begin
                        r_tgt      <= r_tgt + 1'b1;
                        r_tgt_addr <= '0;
                    end else begin
                        r_tgt_addr <= r_tgt_addr + 1'b1;
                    end
                end
            end
            if (w_reboot_ok) begin
                r_err      <= 1'b0;
                r_err_tgt  <= '0;
                r_err_addr <= '0;
                r_rom_addr <= '0;
                r_tgt_addr <= '0;
                r_tgt      <= '0;
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_rom_n_oe = r_rom_n_oe;
    assign o_tgt_addr = r_tgt_addr;
    assign o_tgt_data = r_tgt_data;
    assign o_tgt_n_we = r_tgt_n_we;
    assign o_tgt_n_oe = r_tgt_n_oe;
    assign o_n_booted = r_n_booted;
    assign o_err      = r_err;
    assign o_err_tgt  = r_err_tgt;
    assign o_err_addr = r_err_addr;

endmodule
